// File: rtl/arduino_frame_pkg.sv
`default_nettype none
// ============================================================================
// arduino_frame_pkg: shared state encoding and header field layout for the
// Arduino FIFO frame sequencer.  Revision: 1.0
// ============================================================================
package arduino_frame_pkg;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  localparam int HDR_BIT = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 3;
  localparam int LEN_MSB = 2;
  localparam int LEN_LSB = 0;

  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic [LEN_MSB-LEN_LSB:0] len;
  } frame_hdr_t;

  function automatic frame_hdr_t decode_hdr(input logic [8:0] word);
    frame_hdr_t hdr;
    hdr.opcode = word[OPC_MSB:OPC_LSB];
    hdr.len    = word[LEN_MSB:LEN_LSB];
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arduino_frame_timer.sv
`default_nettype none
// ============================================================================
// arduino_frame_timer: inter-word gap counter; tc fires on the cycle the count
// reaches TIMEOUT_CYC-1 while enabled.  Revision: 1.0
// ============================================================================
module arduino_frame_timer #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int c_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYC - 1);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + c_W'(1);
    end
  end

  assign tc = enable && !clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/arduino_frame_sequencer.sv
`default_nettype none
// ============================================================================
// arduino_frame_sequencer: drains 9-bit words from the Arduino FIFO, assembles
// header+payload frames and offers them on a valid/ready port.
// Optional trailing XOR check word: define FRAME_CHECKSUM_EN.  Revision: 1.0
// ============================================================================
module arduino_frame_sequencer
  import arduino_frame_pkg::*;
#(
  parameter int PAYLOAD_MAX = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic                     fifo_rdempty,
  input  logic [8:0]               fifo_q,
  output logic                     fifo_rdreq,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [4:0]               frame_opcode,
  output logic [2:0]               frame_len,
  output logic [8*PAYLOAD_MAX-1:0] frame_payload,
  output logic                     busy,
  output logic                     err_sync,
  output logic                     err_resync,
  output logic                     err_timeout,
  output logic                     err_len,
  output logic                     err_checksum
);

`ifdef FRAME_CHECKSUM_EN
  localparam state_t c_POST_PAYLOAD = S_CHECK;
  localparam logic   c_VALID_AT_END = 1'b0;
`else
  localparam state_t c_POST_PAYLOAD = S_DELIVER;
  localparam logic   c_VALID_AT_END = 1'b1;
`endif

  state_t                   r_state;
  logic                     r_rd_pending;
  logic [2:0]               r_idx;
  logic [4:0]               r_opcode;
  logic [2:0]               r_len;
  logic [8*PAYLOAD_MAX-1:0] r_payload;
  logic                     r_frame_valid;
  logic                     r_err_sync;
  logic                     r_err_resync;
  logic                     r_err_timeout;
  logic                     r_err_len;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]               r_csum;
  logic                     r_err_checksum;
`endif

  frame_hdr_t w_hdr;
  logic       w_is_hdr;
  logic [7:0] w_byte;
  logic       w_len_ok;
  logic       w_last;
  logic       w_wait_state;
  logic       w_hdr_accept;
  logic       w_timeout;

  assign w_hdr    = decode_hdr(fifo_q);
  assign w_is_hdr = fifo_q[HDR_BIT];
  assign w_byte   = fifo_q[7:0];
  assign w_len_ok = (w_hdr.len <= 3'(PAYLOAD_MAX));
  assign w_last   = (r_idx == (r_len - 3'd1));

`ifdef FRAME_CHECKSUM_EN
  assign w_wait_state = (r_state == S_COLLECT) || (r_state == S_CHECK);
`else
  assign w_wait_state = (r_state == S_COLLECT);
`endif

  // Gated by reset so nothing is popped from the FIFO while held in reset.
  assign fifo_rdreq   = reset && !fifo_rdempty && !r_rd_pending &&
                        ((r_state == S_HUNT) || w_wait_state);
  assign w_hdr_accept = r_rd_pending && w_is_hdr && (r_state != S_DELIVER);

  arduino_frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk_50),
    .reset  (reset),
    .clear  (r_rd_pending || !w_wait_state),
    .enable (w_wait_state),
    .tc     (w_timeout)
  );

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      r_state       <= S_HUNT;
      r_rd_pending  <= 1'b0;
      r_idx         <= '0;
      r_opcode      <= '0;
      r_len         <= '0;
      r_payload     <= '0;
      r_frame_valid <= 1'b0;
      r_err_sync    <= 1'b0;
      r_err_resync  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum         <= '0;
      r_err_checksum <= 1'b0;
`endif
    end else begin
      r_rd_pending  <= fifo_rdreq;
      r_err_sync    <= 1'b0;
      r_err_resync  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_err_checksum <= 1'b0;
`endif
      // A header always restarts framing, abandoning any partial frame.
      if (w_hdr_accept) begin
        r_err_resync <= (r_state != S_HUNT);
        if (w_len_ok) begin
          r_opcode  <= w_hdr.opcode;
          r_len     <= w_hdr.len;
          r_idx     <= '0;
          r_payload <= '0;
`ifdef FRAME_CHECKSUM_EN
          r_csum    <= w_byte;
`endif
          if (w_hdr.len == 3'd0) begin
            r_state       <= c_POST_PAYLOAD;
            r_frame_valid <= c_VALID_AT_END;
          end else begin
            r_state <= S_COLLECT;
          end
        end else begin
          r_err_len <= 1'b1;
          r_state   <= S_HUNT;
        end
      end else begin
        case (r_state)
          S_HUNT: begin
            if (r_rd_pending) r_err_sync <= 1'b1;
          end
          S_COLLECT: begin
            if (r_rd_pending) begin
              for (int i = 0; i < PAYLOAD_MAX; i++) begin
                if (r_idx == 3'(i)) r_payload[8*i +: 8] <= w_byte;
              end
              r_idx <= r_idx + 3'd1;
`ifdef FRAME_CHECKSUM_EN
              r_csum <= r_csum ^ w_byte;
`endif
              if (w_last) begin
                r_state       <= c_POST_PAYLOAD;
                r_frame_valid <= c_VALID_AT_END;
              end
            end else if (w_timeout) begin
              r_err_timeout <= 1'b1;
              r_state       <= S_HUNT;
            end
          end
`ifdef FRAME_CHECKSUM_EN
          S_CHECK: begin
            if (r_rd_pending) begin
              if (w_byte == r_csum) begin
                r_state       <= S_DELIVER;
                r_frame_valid <= 1'b1;
              end else begin
                r_err_checksum <= 1'b1;
                r_state        <= S_HUNT;
              end
            end else if (w_timeout) begin
              r_err_timeout <= 1'b1;
              r_state       <= S_HUNT;
            end
          end
`endif
          S_DELIVER: begin
            if (frame_ready) begin
              r_frame_valid <= 1'b0;
              r_state       <= S_HUNT;
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign frame_valid   = r_frame_valid;
  assign frame_opcode  = r_opcode;
  assign frame_len     = r_len;
  assign frame_payload = r_payload;
  assign busy          = (r_state != S_HUNT);
  assign err_sync      = r_err_sync;
  assign err_resync    = r_err_resync;
  assign err_timeout   = r_err_timeout;
  assign err_len       = r_err_len;
`ifdef FRAME_CHECKSUM_EN
  assign err_checksum  = r_err_checksum;
`else
  assign err_checksum  = 1'b0;
`endif

endmodule
`default_nettype wire
